if_fetch: RTL

Instruction fetch stage directly upstream of the `id_t` decoder. Holds the PC, issues word requests to instruction memory with up to DEPTH requests in flight, buffers returned words in a DEPTH-entry FIFO, and presents each instruction with its PC and one-hot format bits (`r_type`..`j_type`) ready for `id_t`. Supports branch/jump redirect with flush and discard of stale in-flight responses.

---
 rtl/if_fetch.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, response FIFO
// tagged with PCs, redirect flush with stale-response discard, format decode.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        r_type,
    output logic        i_type,
    output logic        s_type,
    output logic        b_type,
    output logic        u_type,
    output logic        j_type,
    output logic        illegal
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   fifo_word [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   tag_q     [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] tag_rd;
    logic [AW-1:0] tag_wr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW:0]   used;
    logic          acc;
    logic          rsp;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_aligned;
    logic [6:0]    op;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    assign used = {1'b0, inflight} + {1'b0, count};

    // Buffered entries reserve credit so a returning word always has a slot.
    assign imem_req_valid = rst_n && !redirect_valid && (used < CAP);
    assign imem_req_addr  = pc;
    assign acc  = imem_req_valid && imem_req_ready;
    assign rsp  = imem_rsp_valid && (inflight != '0);
    assign push = rsp && (drop == '0) && !redirect_valid;

    assign instr_valid = (count != '0);
    assign pop      = instr_valid && instr_ready && !redirect_valid;
    assign instr    = instr_valid ? fifo_word[rd_ptr] : '0;
    assign instr_pc = instr_valid ? fifo_pc[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_aligned;
            end else if (acc) begin
                pc <= pc + 32'd4;
            end
            if (acc) begin
                tag_wr <= tag_wr + AW'(1);
            end
            if (rsp) begin
                tag_rd <= tag_rd + AW'(1);
            end
            inflight <= inflight + CW'(acc) - CW'(rsp);
            // Every request still outstanding after a redirect is stale.
            if (redirect_valid) begin
                drop   <= inflight - CW'(rsp);
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (rsp && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            tag_q[tag_wr] <= pc;
        end
        if (push) begin
            fifo_word[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= tag_q[tag_rd];
        end
    end

    assign op = instr[6:0];

    always_comb begin
        r_type  = 1'b0;
        i_type  = 1'b0;
        s_type  = 1'b0;
        b_type  = 1'b0;
        u_type  = 1'b0;
        j_type  = 1'b0;
        illegal = 1'b0;
        if (instr_valid) begin
            case (op)
                7'b0110011: r_type = 1'b1;
                7'b0010011,
                7'b0000011,
                7'b1100111,
                7'b1110011: i_type = 1'b1;
                7'b0100011: s_type = 1'b1;
                7'b1100011: b_type = 1'b1;
                7'b0110111,
                7'b0010111: u_type = 1'b1;
                7'b1101111: j_type = 1'b1;
                default:    illegal = 1'b1;
            endcase
        end
    end

endmodule
